div: RTL

- Sequential signed fixed-point divider; the inverse companion to the existing add/sub/mul fixed-point blocks.
- Same operand format and same calculate_en start convention as those blocks.
- Computes valueOne / valueTwo by radix-2 restoring division over magnitudes, one quotient bit per clock.
- Saturates on overflow and on divide-by-zero.

---
 rtl/fixedpoint_pkg.sv | 37 +++
 rtl/div_step.sv | 29 ++
 rtl/div.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fixedpoint_pkg.sv
// Shared definitions for the fixed-point arithmetic blocks (add/sub/mul/div).
//   - default operand widths and the width-derivation helpers
//   - div FSM state enum
//   - saturation constants max_pos / max_neg for any operand width up to MaxWidth
package fixedpoint_pkg;

    localparam int unsigned DefWholeWidth    = 16;
    localparam int unsigned DefFractionWidth = 16;
    localparam int unsigned MaxWidth         = 64;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } div_state_e;

    // Operand width W.
    function automatic int unsigned op_width(int unsigned whole_w, int unsigned frac_w);
        return whole_w + frac_w;
    endfunction

    // Division iteration count N: the dividend is pre-scaled by 2^frac_w.
    function automatic int unsigned iter_count(int unsigned whole_w, int unsigned frac_w);
        return whole_w + 2 * frac_w;
    endfunction

    // Largest positive two's complement value of width w, in the low w bits.
    function automatic logic [MaxWidth-1:0] max_pos(int unsigned w);
        return (MaxWidth'(1) << (w - 1)) - MaxWidth'(1);
    endfunction

    // Most negative two's complement value of width w, in the low w bits.
    function automatic logic [MaxWidth-1:0] max_neg(int unsigned w);
        return ~max_pos(w);
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step (purely combinational).
// Ports:
//   rem_i  partial remainder (always < den_i)
//   bit_i  next numerator bit shifted in
//   den_i  divisor magnitude
//   rem_o  updated partial remainder
//   q_o    quotient bit produced by this step
module div_step #(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0] rem_i,
    input  logic             bit_i,
    input  logic [Width-1:0] den_i,
    output logic [Width-1:0] rem_o,
    output logic             q_o
);

    logic [Width:0]   trial;
    logic [Width-1:0] diff;

    always_comb begin
        trial = {rem_i, bit_i};
        q_o   = (trial >= {1'b0, den_i});
        // When the subtraction happens the true difference is < den_i, so W bits suffice.
        diff  = trial[Width-1:0] - den_i;
        rem_o = q_o ? diff : trial[Width-1:0];
    end

endmodule

// File: rtl/div.sv
// Sequential signed fixed-point divider: quotient = valueOne / valueTwo.
// Restoring division over magnitudes, one quotient bit per clock, saturating on overflow
// and on divide-by-zero.
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-high reset
//   calculate_en     start request, sampled only while idle
//   valueOne         dividend, signed Q(wholeWidth).(fractionWidth)
//   valueTwo         divisor, same format
//   quotient         signed result, held until the next completion
//   valid            one-cycle completion pulse
//   busy             high from accept until valid rises
//   divByZero        valid-qualified: divisor was zero
//   overflow         valid-qualified: result saturated for a non-zero divisor
// Build option: define DIV_ROUND_EN to round the magnitude to nearest (ties away from
// zero) using one extra guard iteration.
module div
    import fixedpoint_pkg::*;
#(
    parameter int unsigned wholeWidth    = DefWholeWidth,
    parameter int unsigned fractionWidth = DefFractionWidth
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                calculate_en,
    input  logic [wholeWidth+fractionWidth-1:0] valueOne,
    input  logic [wholeWidth+fractionWidth-1:0] valueTwo,
    output logic [wholeWidth+fractionWidth-1:0] quotient,
    output logic                                valid,
    output logic                                busy,
    output logic                                divByZero,
    output logic                                overflow
);

    localparam int unsigned W = op_width(wholeWidth, fractionWidth);
    localparam int unsigned N = iter_count(wholeWidth, fractionWidth);
`ifdef DIV_ROUND_EN
    localparam int unsigned Iters = N + 1;
`else
    localparam int unsigned Iters = N;
`endif
    localparam int unsigned CntW = $clog2(Iters + 1);

    localparam logic [W-1:0] MaxPos    = W'(max_pos(W));
    localparam logic [W-1:0] MaxNeg    = W'(max_neg(W));
    localparam logic [N:0]   MagPosLim = {{(N + 2 - W){1'b0}}, {(W - 1){1'b1}}};
    localparam logic [N:0]   MagNegLim = MagPosLim + (N + 1)'(1);

    div_state_e       state_q;
    logic [Iters-1:0] num_q;
    logic [Iters-1:0] quo_q;
    logic [W-1:0]     den_q;
    logic [W-1:0]     rem_q;
    logic [CntW-1:0]  cnt_q;
    logic             neg_q;
    logic             one_neg_q;
    logic             one_zero_q;
    logic             dz_q;
    logic             dz_wait_q;

    logic [W-1:0] mag_one;
    logic [W-1:0] mag_two;
    logic [W-1:0] step_rem;
    logic         step_q;
    logic [N:0]   mag;
    logic [W-1:0] sat_quo;
    logic         sat_ovf;

    // Unsigned W-bit magnitude: the most negative operand maps to 2^(W-1) without wrapping.
    always_comb begin
        mag_one = valueOne[W-1] ? (~valueOne + W'(1)) : valueOne;
        mag_two = valueTwo[W-1] ? (~valueTwo + W'(1)) : valueTwo;
    end

    div_step #(
        .Width (W)
    ) u_step (
        .rem_i (rem_q),
        .bit_i (num_q[Iters-1]),
        .den_i (den_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // Round (optional), apply sign, saturate.
    always_comb begin
`ifdef DIV_ROUND_EN
        // Guard bit set means the discarded fraction is >= 1/2.
        mag = {1'b0, quo_q[Iters-1:1]} + {{N{1'b0}}, quo_q[0]};
`else
        mag = {1'b0, quo_q};
`endif
        sat_ovf = 1'b0;
        if (neg_q) begin
            if (mag > MagNegLim) begin
                sat_quo = MaxNeg;
                sat_ovf = 1'b1;
            end else begin
                sat_quo = ~mag[W-1:0] + W'(1);
            end
        end else begin
            if (mag > MagPosLim) begin
                sat_quo = MaxPos;
                sat_ovf = 1'b1;
            end else begin
                sat_quo = mag[W-1:0];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            num_q      <= '0;
            quo_q      <= '0;
            den_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            one_neg_q  <= 1'b0;
            one_zero_q <= 1'b0;
            dz_q       <= 1'b0;
            dz_wait_q  <= 1'b0;
            quotient   <= '0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            divByZero  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    valid <= 1'b0;
                    if (calculate_en) begin
                        busy       <= 1'b1;
                        num_q      <= {mag_one, {(Iters - W){1'b0}}};
                        den_q      <= mag_two;
                        rem_q      <= '0;
                        quo_q      <= '0;
                        cnt_q      <= '0;
                        neg_q      <= valueOne[W-1] ^ valueTwo[W-1];
                        one_neg_q  <= valueOne[W-1];
                        one_zero_q <= (valueOne == '0);
                        if (valueTwo == '0) begin
                            dz_q      <= 1'b1;
                            dz_wait_q <= 1'b1;
                            state_q   <= StDone;
                        end else begin
                            dz_q    <= 1'b0;
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    rem_q <= step_rem;
                    num_q <= num_q << 1;
                    quo_q <= {quo_q[Iters-2:0], step_q};
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(Iters - 1)) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    // Divide-by-zero lingers one cycle here so valid lands two cycles after accept.
                    if (dz_wait_q) begin
                        dz_wait_q <= 1'b0;
                    end else begin
                        valid   <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                        if (dz_q) begin
                            quotient  <= one_zero_q ? '0 : (one_neg_q ? MaxNeg : MaxPos);
                            divByZero <= 1'b1;
                            overflow  <= 1'b0;
                        end else begin
                            quotient  <= sat_quo;
                            divByZero <= 1'b0;
                            overflow  <= sat_ovf;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
